// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage hazard/forwarding bus: master is the pipeline datapath, slave is the controller.
// Signal names keep the _i/_o direction of the controller so both sides read the same.
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int CNT_W  = 16
);
  localparam int FW = $clog2(DEPTH);

  logic              id_valid_i;
  logic [REG_AW-1:0] id_rs_i;
  logic [REG_AW-1:0] id_rt_i;
  logic              id_use_rs_i;
  logic              id_use_rt_i;
  logic [REG_AW-1:0] id_dst_i;
  logic              id_regwrite_i;
  logic              id_memread_i;
  logic              br_taken_i;
  logic [FW-1:0]     fwd_a_o;
  logic [FW-1:0]     fwd_b_o;
  logic              pc_write_o;
  logic              if_id_write_o;
  logic              if_id_flush_o;
  logic              id_ex_bubble_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  flush_cnt_o;

  modport master (
    output id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
           id_dst_i, id_regwrite_i, id_memread_i, br_taken_i,
    input  fwd_a_o, fwd_b_o, pc_write_o, if_id_write_o, if_id_flush_o,
           id_ex_bubble_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
           id_dst_i, id_regwrite_i, id_memread_i, br_taken_i,
    output fwd_a_o, fwd_b_o, pc_write_o, if_id_write_o, if_id_flush_o,
           id_ex_bubble_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Forwarding/load-use/branch-flush control; all controls combinational off registered tags, stall = LOAD_LAT-s cycles.
// Statistics counters exist only when PIPE_HAZARD_STATS_EN is defined, otherwise they read as zero.
module pipe_hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int BR_STAGE = 1,
  parameter int CNT_W    = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  pipe_hazard_ctrl_if.slave  ctl
);
  localparam int FW = $clog2(DEPTH);

  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] dst;
    logic              rw;
    logic              mr;
  } tag_t;

  typedef struct packed {
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              use_rs;
    logic              use_rt;
  } src_t;

  tag_t [DEPTH-1:0] tag_q, tag_d;
  src_t             src_q, src_d;
  logic             br, hz, bubble;
  logic [FW-1:0]    fwd_a, fwd_b;

  function automatic logic can_fwd(tag_t t, int k);
    return t.vld && t.rw && (t.dst != '0) && (!t.mr || k >= LOAD_LAT);
  endfunction

  // Reset must not leak a flush even if the branch input is high.
  assign br = ctl.br_taken_i & ~rst_i;

  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    // Walk oldest to youngest so the nearest producer wins.
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (can_fwd(tag_q[k], k) && src_q.use_rs && (tag_q[k].dst == src_q.rs)) fwd_a = k[FW-1:0];
      if (can_fwd(tag_q[k], k) && src_q.use_rt && (tag_q[k].dst == src_q.rt)) fwd_b = k[FW-1:0];
    end
  end

  always_comb begin
    hz = 1'b0;
    for (int s = 0; s < LOAD_LAT; s++) begin
      if (tag_q[s].vld && tag_q[s].mr && (tag_q[s].dst != '0) &&
          ((ctl.id_use_rs_i && (tag_q[s].dst == ctl.id_rs_i)) ||
           (ctl.id_use_rt_i && (tag_q[s].dst == ctl.id_rt_i))))
        hz = 1'b1;
    end
    hz     = hz & ctl.id_valid_i & ~br;
    bubble = br | hz;
  end

  always_comb begin
    tag_d        = '0;
    tag_d[0].vld = ctl.id_valid_i & ~bubble;
    tag_d[0].dst = ctl.id_dst_i;
    tag_d[0].rw  = ctl.id_regwrite_i;
    tag_d[0].mr  = ctl.id_memread_i;
    // Everything younger than the resolving branch is squashed.
    for (int k = 1; k < DEPTH; k++)
      tag_d[k] = (br && (k <= BR_STAGE)) ? '0 : tag_q[k-1];
    src_d.rs     = ctl.id_rs_i;
    src_d.rt     = ctl.id_rt_i;
    src_d.use_rs = ctl.id_use_rs_i & ~bubble;
    src_d.use_rt = ctl.id_use_rt_i & ~bubble;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tag_q <= '0;
      src_q <= '0;
    end else begin
      tag_q <= tag_d;
      src_q <= src_d;
    end
  end

  assign ctl.fwd_a_o        = fwd_a;
  assign ctl.fwd_b_o        = fwd_b;
  assign ctl.pc_write_o     = ~hz;
  assign ctl.if_id_write_o  = ~hz;
  assign ctl.if_id_flush_o  = br;
  assign ctl.id_ex_bubble_o = bubble;

`ifdef PIPE_HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hz && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (br && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ctl.stall_cnt_o = stall_cnt_q;
  assign ctl.flush_cnt_o = flush_cnt_q;
`else
  assign ctl.stall_cnt_o = {CNT_W{1'b0}};
  assign ctl.flush_cnt_o = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: two controllers (default and LOAD_LAT=2/CNT_W=4) fed from one stimulus sequence,
// expected values queued when stimulus is driven and compared when the cycle comes due.
module tb_pipe_hazard_ctrl;
  localparam int FWDA = 0, FWDB = 1, PCW = 2, IFW = 3, FLS = 4, BUB = 5, SCNT = 6, FCNT = 7;
`ifdef PIPE_HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if ifa ();
  pipe_hazard_ctrl_if #(.CNT_W(4)) ifb ();

  pipe_hazard_ctrl u_a (.clk_i(clk), .rst_i(rst), .ctl(ifa));
  pipe_hazard_ctrl #(.LOAD_LAT(2), .CNT_W(4)) u_b (.clk_i(clk), .rst_i(rst), .ctl(ifb));

  typedef struct {
    int          due;
    int          dut;
    int          sig;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic put(input int m, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic urs, input logic urt, input logic [4:0] dst,
                     input logic rw, input logic mr);
    if (m[0]) begin
      ifa.id_valid_i = v; ifa.id_rs_i = rs; ifa.id_rt_i = rt; ifa.id_use_rs_i = urs;
      ifa.id_use_rt_i = urt; ifa.id_dst_i = dst; ifa.id_regwrite_i = rw; ifa.id_memread_i = mr;
    end
    if (m[1]) begin
      ifb.id_valid_i = v; ifb.id_rs_i = rs; ifb.id_rt_i = rt; ifb.id_use_rs_i = urs;
      ifb.id_use_rt_i = urt; ifb.id_dst_i = dst; ifb.id_regwrite_i = rw; ifb.id_memread_i = mr;
    end
  endtask

  task automatic nop(input int m);
    put(m, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic set_br(input logic b);
    ifa.br_taken_i = b;
    ifb.br_taken_i = b;
  endtask

  task automatic expv(input int d, input int dut, input int sig, input logic [31:0] v, input string nm);
    sb.push_back('{cyc + d, dut, sig, v, nm});
  endtask

  function automatic logic [31:0] obs(input int dut, input int sig);
    if (dut == 0) begin
      case (sig)
        FWDA:    return 32'(ifa.fwd_a_o);
        FWDB:    return 32'(ifa.fwd_b_o);
        PCW:     return 32'(ifa.pc_write_o);
        IFW:     return 32'(ifa.if_id_write_o);
        FLS:     return 32'(ifa.if_id_flush_o);
        BUB:     return 32'(ifa.id_ex_bubble_o);
        SCNT:    return 32'(ifa.stall_cnt_o);
        default: return 32'(ifa.flush_cnt_o);
      endcase
    end else begin
      case (sig)
        FWDA:    return 32'(ifb.fwd_a_o);
        FWDB:    return 32'(ifb.fwd_b_o);
        PCW:     return 32'(ifb.pc_write_o);
        IFW:     return 32'(ifb.if_id_write_o);
        FLS:     return 32'(ifb.if_id_flush_o);
        BUB:     return 32'(ifb.id_ex_bubble_o);
        SCNT:    return 32'(ifb.stall_cnt_o);
        default: return 32'(ifb.flush_cnt_o);
      endcase
    end
  endfunction

  task automatic check_due();
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        logic [31:0] o;
        o = obs(sb[i].dut, sb[i].sig);
        n_chk++;
        assert (o === sb[i].exp) else begin
          n_fail++;
          $error("FAIL %s: observed %0h expected %0h (cycle %0d)", sb[i].name, o, sb[i].exp, cyc);
        end
        sb.delete(i);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_due();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    // Reset with a taken branch and a real ID instruction present.
    rst = 1'b1;
    set_br(1'b1);
    put(3, 1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    expv(0, 0, FWDA, 0, "rst_fwd_a"); expv(0, 0, FWDB, 0, "rst_fwd_b");
    expv(0, 0, PCW, 1, "rst_pcw");    expv(0, 0, IFW, 1, "rst_ifw");
    expv(0, 0, FLS, 0, "rst_flush");  expv(0, 0, BUB, 0, "rst_bubble");
    expv(0, 0, SCNT, 0, "rst_scnt");  expv(0, 0, FCNT, 0, "rst_fcnt");
    expv(0, 1, FLS, 0, "rst_flush_b");
    tick();
    rst = 1'b0; set_br(1'b0); nop(3); tick();

    // ALU result forwarded from MEM.
    put(3, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0); tick();
    put(3, 1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    expv(1, 0, FWDA, 1, "alu_fwd_a"); expv(1, 0, FWDB, 0, "alu_fwd_b"); expv(1, 1, FWDA, 1, "alu_fwd_a_b");
    tick();
    nop(3); tick();
    nop(3); expv(0, 0, FWDA, 0, "nop_fwd_a"); tick();

    // Two producers of $3: nearest wins.
    put(3, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0); tick();
    put(3, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0); tick();
    put(3, 1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
    expv(1, 0, FWDA, 1, "near_fwd_a"); expv(1, 0, FWDB, 1, "near_fwd_b");
    tick();
    nop(3); tick();
    nop(3); tick();

    // Producer two stages ahead forwards from WB; rt not used.
    put(3, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0); tick();
    nop(3); tick();
    put(3, 1'b1, 5'd8, 5'd9, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0);
    expv(1, 0, FWDA, 2, "far_fwd_a"); expv(1, 0, FWDB, 0, "far_fwd_b");
    tick();
    nop(3); tick(); nop(3); tick(); nop(3); tick();

    // Load-use: lw $2 then add $6,$2,$2 held in ID while stalled.
    put(3, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1); tick();
    put(3, 1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    expv(0, 0, PCW, 0, "lu_pcw"); expv(0, 0, IFW, 0, "lu_ifw"); expv(0, 0, BUB, 1, "lu_bubble");
    expv(0, 0, FLS, 0, "lu_flush"); expv(0, 1, PCW, 0, "lu2_pcw_0");
    tick();
    expv(0, 0, PCW, 1, "lu_release_pcw"); expv(0, 0, BUB, 0, "lu_release_bubble");
    expv(0, 1, PCW, 0, "lu2_pcw_1"); expv(0, 1, BUB, 1, "lu2_bubble_1");
    expv(0, 0, SCNT, STATS ? 1 : 0, "lu_stall_cnt");
    tick();
    nop(1);
    expv(0, 0, FWDA, 2, "lu_fwd_a"); expv(0, 0, FWDB, 2, "lu_fwd_b");
    expv(0, 1, PCW, 1, "lu2_release_pcw"); expv(0, 1, SCNT, STATS ? 2 : 0, "lu2_stall_cnt");
    tick();
    nop(3); expv(0, 1, FWDA, 0, "lu2_fwd_a"); tick();
    nop(3); tick(); nop(3); tick();

    // Load at tag 1 with a reader in EX: forwardable only when LOAD_LAT is 1.
    put(3, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1); tick();
    put(3, 1'b0, 5'd2, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    expv(0, 0, PCW, 1, "gate_no_stall");
    tick();
    nop(3); expv(0, 0, FWDA, 1, "gate_fwd_ll1"); expv(0, 1, FWDA, 0, "gate_fwd_ll2"); tick();
    nop(3); tick(); nop(3); tick();

    // Register 0 never forwards or stalls.
    put(3, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0); tick();
    put(3, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0); tick();
    nop(3); expv(0, 0, FWDA, 0, "r0_fwd_a"); expv(0, 0, FWDB, 0, "r0_fwd_b"); tick();
    put(3, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1); tick();
    put(3, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    expv(0, 0, PCW, 1, "r0_no_stall"); expv(0, 0, BUB, 0, "r0_no_bubble"); expv(0, 1, PCW, 1, "r0_no_stall_b");
    tick();
    nop(3); tick(); nop(3); tick(); nop(3); tick();

    // Taken branch coincident with a load-use.
    put(3, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1); tick();
    put(3, 1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    set_br(1'b1);
    expv(0, 0, FLS, 1, "br_flush"); expv(0, 0, BUB, 1, "br_bubble");
    expv(0, 0, PCW, 1, "br_pcw");   expv(0, 0, IFW, 1, "br_ifw");
    expv(0, 1, FLS, 1, "br_flush_b"); expv(0, 1, PCW, 1, "br_pcw_b");
    tick();
    set_br(1'b0);
    put(3, 1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    expv(0, 1, PCW, 1, "br_tag1_flushed");
    expv(0, 0, FCNT, STATS ? 1 : 0, "br_flush_cnt"); expv(0, 0, SCNT, STATS ? 1 : 0, "br_stall_cnt");
    expv(0, 1, FCNT, STATS ? 1 : 0, "br_flush_cnt_b"); expv(0, 1, SCNT, STATS ? 2 : 0, "br_stall_cnt_b");
    tick();
    nop(3); expv(0, 0, FWDA, 0, "br_fwd_a"); expv(0, 0, FWDB, 0, "br_fwd_b"); tick();
    nop(3); tick(); nop(3); tick();

    // Flush counter saturation: 4-bit counter must stick at 15.
    for (int i = 0; i < 20; i++) begin
      set_br(1'b1); nop(3); tick();
    end
    set_br(1'b0); nop(3);
    expv(0, 0, FCNT, STATS ? 21 : 0, "sat_flush_cnt");
    expv(0, 1, FCNT, STATS ? 15 : 0, "sat_flush_cnt_b");
    tick();

    // Reset mid-stream during a load-use with a taken branch.
    put(3, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1); tick();
    rst = 1'b1; set_br(1'b1);
    put(3, 1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    expv(0, 0, FWDA, 0, "mrst_fwd_a"); expv(0, 0, PCW, 1, "mrst_pcw");
    expv(0, 0, IFW, 1, "mrst_ifw");    expv(0, 0, FLS, 0, "mrst_flush");
    expv(0, 0, BUB, 0, "mrst_bubble"); expv(0, 0, SCNT, 0, "mrst_scnt");
    expv(0, 0, FCNT, 0, "mrst_fcnt");  expv(0, 1, FCNT, 0, "mrst_fcnt_b");
    expv(0, 1, PCW, 1, "mrst_pcw_b");
    tick();
    rst = 1'b0; set_br(1'b0);
    expv(0, 0, PCW, 1, "post_rst_pcw"); expv(0, 1, PCW, 1, "post_rst_pcw_b");
    tick();
    nop(3); expv(0, 0, FWDA, 0, "post_rst_fwd_a"); tick();
    nop(3); tick();

    n_chk++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL pending_expectations: observed %0d expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
